div32_seq: RTL and testbench
============================

Name: div32_seq

Overview:
- Multi-cycle 32-bit integer divider.
- Sits downstream of the 32-bit carry-lookahead adder `add`: it instantiates one `add` and feeds its sum/cout back into a partial-remainder register each cycle (non-restoring algorithm).
- Supplies the ALU's DIV result: quotient to LO, remainder to HI.
- Signed and unsigned operation, selected per request.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is legal because the adder datapath is fixed at 32 bits; the parameter exists for assertions and counter sizing.

Ports:
- clock  input  1  rising-edge clock
- clear  input  1  asynchronous, active-low reset
- start  input  1  request; accepted only on a rising edge in IDLE with clear high
- signed_op  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start
- dividend  input  32  numerator; sampled with start
- divisor  input  32  denominator; sampled with start
- busy  output  1  high from the accepting edge until done is raised
- done  output  1  single-cycle pulse; results valid from this cycle on
- quotient  output  32  result quotient (LO)
- remainder  output  32  result remainder (HI)
- div_by_zero  output  1  set with done when divisor == 0

Behaviour:
- Reset (clear low, asynchronous):
  - state = IDLE; busy, done and div_by_zero = 0; quotient and remainder = 0.
  - Any operation in progress is discarded. Takes effect immediately, mid-iteration included.
- States: IDLE, RUN, CORRECT, DONE.
- IDLE:
  - On start=1 with divisor != 0: latch magnitudes |dividend| and |divisor| (magnitude only if signed_op and the MSB is set; the magnitude is an unsigned 32-bit value, so |0x80000000| = 0x80000000).
  - Also latch qsign = signed_op & (dividend[31] ^ divisor[31]) and rsign = signed_op & dividend[31].
  - Clear the 33-bit partial remainder A, set count = 0, go to RUN, busy = 1.
- Divide by zero: on start=1 with divisor == 0, go directly to DONE with quotient = 0xFFFFFFFF, remainder = dividend (unaltered), div_by_zero = 1.
- RUN (exactly 32 cycles), each cycle:
  - Shift {A,Q} left 1.
  - If A was non-negative, A = A - M; otherwise A = A + M.
  - Set Q[0] = ~A_new[32].
  - After the 32nd iteration, go to CORRECT.
- Add/sub datapath:
  - Low 32 bits come from the single `add` instance: Rb = M or ~M, cin = subtract.
  - A[32] = A_sh[32] XOR subtract XOR cout.
  - No behavioural '+' or '-' in the iteration path. The sign fixups in IDLE/CORRECT may use behavioural negation.
- CORRECT (1 cycle):
  - If A < 0, restore A = A + M.
  - Apply signs: quotient = qsign ? -Q : Q; remainder = rsign ? -A[31:0] : A[31:0].
  - Register both outputs and go to DONE.
- DONE (1 cycle): done = 1, busy = 0, then return to IDLE.
- Latency:
  - With the accepting edge as edge 0, done is high after edge 34 (32 RUN edges, 1 CORRECT edge).
  - For divide-by-zero, done is high after edge 1.
- Output hold: quotient, remainder and div_by_zero hold until the next accepted start. At acceptance, div_by_zero clears to 0 and the results keep their old values until CORRECT.
- start while busy or in DONE is ignored, with no queuing. start in the DONE cycle is also ignored; it is accepted only from IDLE.
- Operand inputs may change freely after acceptance.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0, no flag.
- Semantics: truncating division; the remainder takes the dividend's sign. Unsigned mode treats all 32 bits as magnitude.

Decomposition:
- Shared CPU package holds:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, CORRECT=2'd2, DONE=2'd3.
  - DIV_ITERS = 32.
  - DIV_ZERO_QUOTIENT = 32'hFFFFFFFF.
- Sub-module: one instance of the existing `add` (32-bit CLA) as the iteration adder. No other sub-module.

Test Plan:
- signed 100 / 7 -> busy for 34 cycles; done pulses once after edge 34; quotient 0x0000000E, remainder 0x00000002.
- signed -100 / 7 -> quotient 0xFFFFFFF2, remainder 0xFFFFFFFE. Signed 100 / -7 -> quotient 0xFFFFFFF2, remainder 0x00000002.
- unsigned 0xFFFFFFFF / 0x00000002 -> quotient 0x7FFFFFFF, remainder 0x00000001. Same operands signed (-1/2) -> quotient 0, remainder 0xFFFFFFFF.
- 55 / 0 (either mode) -> done after edge 1; div_by_zero=1, quotient 0xFFFFFFFF, remainder 0x00000037. Next valid op clears the flag.
- signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, div_by_zero 0.
- Abort and ignore:
  - start 100/7, pulse start again at iteration 5 with 9/3 -> second request ignored, result 14 r 2.
  - Assert clear at iteration 10 -> busy, done and results 0 immediately.
  - After release, 9/3 -> quotient 3, remainder 0.

Source files
------------

// File: rtl/div32_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div32_seq_pkg
//  Purpose  : Shared CPU definitions for the sequential divider: FSM state
//             encoding, iteration count, divide-by-zero quotient and an
//             operand magnitude helper.
//  Revision : 1.0 - initial release
// ============================================================================
package div32_seq_pkg;

    // Divider control states (2-bit encoding, fixed values)
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        CORRECT = 2'd2,
        DONE    = 2'd3
    } div_state_t;

    localparam int          DIV_ITERS         = 32;
    localparam logic [31:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

    // Unsigned magnitude of an operand; only negated when the operation is
    // signed and the operand is negative. |0x80000000| stays 0x80000000.
    function automatic logic [31:0] op_magnitude(input logic [31:0] value,
                                                 input logic        is_signed);
        logic [31:0] result;
        result = value;
        if (is_signed && value[31]) begin
            result = -value;
        end
        return result;
    endfunction

endpackage : div32_seq_pkg
`default_nettype wire

// File: rtl/add.sv
`default_nettype none
// ============================================================================
//  Module   : add
//  Purpose  : 32-bit carry-lookahead adder. Eight 4-bit lookahead groups with
//             a second lookahead level across the group carries.
//  Revision : 1.0 - initial release
// ============================================================================
module add (
    input  logic [31:0] ra,
    input  logic [31:0] rb,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    // Generate/propagate, group lookahead and per-bit carries in one pass
    always_comb begin
        logic [31:0] g;
        logic [31:0] p;
        logic [31:0] carry;
        logic [7:0]  grp_g;
        logic [7:0]  grp_p;
        logic [8:0]  grp_c;

        g     = ra & rb;
        p     = ra ^ rb;
        carry = '0;
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;

        for (int i = 0; i < 8; i++) begin
            grp_g[i] = g[4*i+3]
                     | (p[4*i+3] & g[4*i+2])
                     | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                     | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
            grp_p[i] = &p[4*i +: 4];
        end

        grp_c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            grp_c[i+1] = grp_g[i] | (grp_p[i] & grp_c[i]);
        end

        for (int i = 0; i < 8; i++) begin
            carry[4*i]   = grp_c[i];
            carry[4*i+1] = g[4*i] | (p[4*i] & grp_c[i]);
            carry[4*i+2] = g[4*i+1]
                         | (p[4*i+1] & g[4*i])
                         | (p[4*i+1] & p[4*i] & grp_c[i]);
            carry[4*i+3] = g[4*i+2]
                         | (p[4*i+2] & g[4*i+1])
                         | (p[4*i+2] & p[4*i+1] & g[4*i])
                         | (p[4*i+2] & p[4*i+1] & p[4*i] & grp_c[i]);
        end

        sum  = p ^ carry;
        cout = grp_c[8];
    end

endmodule : add
`default_nettype wire

// File: rtl/div32_seq.sv
`default_nettype none
// ============================================================================
//  Module   : div32_seq
//  Purpose  : Multi-cycle 32-bit non-restoring integer divider (signed or
//             unsigned per request). Quotient feeds LO, remainder feeds HI.
//             The iteration add/subtract runs through one `add` instance.
//  Revision : 1.0 - initial release
// ============================================================================
module div32_seq
    import div32_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    // The adder datapath is fixed at 32 bits, so WIDTH is only meaningful
    // at 32; it sizes the iteration counter and the port widths.
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITERS - 1);

    div_state_t       state;
    div_state_t       state_nxt;

    logic [WIDTH:0]   acc;        // 33-bit partial remainder A
    logic [WIDTH-1:0] quo;        // quotient / dividend shift register Q
    logic [WIDTH-1:0] mag_m;      // divisor magnitude M
    logic [CNT_W-1:0] count;
    logic             qsign;
    logic             rsign;

    logic             accept;
    logic             zero_div;
    logic             last_iter;
    logic [WIDTH:0]   acc_sh;
    logic             subtract;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic [WIDTH:0]   acc_new;
    logic [WIDTH-1:0] rem_fix;

    assign accept    = start && (state == IDLE);
    assign zero_div  = (divisor == '0);
    assign last_iter = (count == LAST_ITER);
    assign busy      = (state != IDLE);

    // One non-restoring step: shift {A,Q} left, then add or subtract M
    // depending on the sign of A before the shift.
    assign acc_sh   = {acc[WIDTH-1:0], quo[WIDTH-1]};
    assign subtract = ~acc[WIDTH];
    assign add_b    = subtract ? ~mag_m : mag_m;

    add u_add (
        .ra   (acc_sh[WIDTH-1:0]),
        .rb   (add_b),
        .cin  (subtract),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Bit 32 of the 33-bit result: sign-extension of the operands plus carry
    assign acc_new = {acc_sh[WIDTH] ^ subtract ^ add_cout, add_sum};

    // Final restore step when the partial remainder ended negative
    assign rem_fix = acc[WIDTH] ? (acc[WIDTH-1:0] + mag_m) : acc[WIDTH-1:0];

    // State register
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = zero_div ? DONE : RUN;
            RUN:     if (last_iter) state_nxt = CORRECT;
            CORRECT: state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, iteration registers, result registers and done pulse
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            acc         <= '0;
            quo         <= '0;
            mag_m       <= '0;
            count       <= '0;
            qsign       <= 1'b0;
            rsign       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (accept) begin
                div_by_zero <= zero_div;
                if (zero_div) begin
                    quotient  <= DIV_ZERO_QUOTIENT;
                    remainder <= dividend;
                end else begin
                    acc   <= '0;
                    quo   <= op_magnitude(dividend, signed_op);
                    mag_m <= op_magnitude(divisor, signed_op);
                    qsign <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    rsign <= signed_op & dividend[WIDTH-1];
                    count <= '0;
                end
            end else if (state == RUN) begin
                acc   <= acc_new;
                quo   <= {quo[WIDTH-2:0], ~acc_new[WIDTH]};
                count <= count + 1'b1;
            end else if (state == CORRECT) begin
                quotient  <= qsign ? -quo : quo;
                remainder <= rsign ? -rem_fix : rem_fix;
            end
        end
    end

endmodule : div32_seq
`default_nettype wire

// File: tb/tb_div32_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div32_seq
//  Purpose  : Self-checking bench for div32_seq: directed cases, random
//             operands against an arithmetic reference, abort/ignore cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div32_seq;

    logic        clock;
    logic        clear;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;

    div32_seq #(.WIDTH(32)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: truncating division, remainder follows the dividend sign
    function automatic void model(input logic s, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] q,
                                  output logic [31:0] r, output logic dz);
        longint sa, sb, sq, sr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
        end else if (!s) begin
            q = a / b; r = a % b; dz = 1'b0;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[31:0];
            r  = sr[31:0];
            dz = 1'b0;
        end
    endfunction

    // Issue one request and wait (bounded) for done; report latency in edges
    // after the accepting edge, busy-high cycles, and done one cycle later.
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcnt, output logic done_after,
                          output logic [31:0] q, output logic [31:0] r, output logic dz);
        @(negedge clock);
        start = 1'b1; signed_op = s; dividend = a; divisor = b;
        @(posedge clock); #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom; signed_op = $urandom_range(0, 1);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(posedge clock); #1;
            lat++;
            if (busy) bcnt++;
        end
        q = quotient; r = remainder; dz = div_by_zero;
        @(posedge clock); #1;
        done_after = done;
    endtask

    task automatic test_reset();
        clear = 1'b0; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clock);
        #1;
        total++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 67'd0) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b dz=%b q=%h r=%h, want all zero",
                     busy, done, div_by_zero, quotient, remainder);
        end
        @(negedge clock);
        clear = 1'b1;
    endtask

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t vt[8];
        int lat, bcnt;
        logic da, dz;
        logic [31:0] q, r;
        vt[0] = '{1'b1, 32'd100,        32'd7,          32'h0000_000E, 32'h0000_0002, 1'b0, 34};
        vt[1] = '{1'b1, -32'sd100,      32'd7,          32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34};
        vt[2] = '{1'b1, 32'd100,        -32'sd7,        32'hFFFF_FFF2, 32'h0000_0002, 1'b0, 34};
        vt[3] = '{1'b0, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 34};
        vt[4] = '{1'b1, 32'hFFFF_FFFF,  32'd2,          32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 34};
        vt[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 32'h0000_0000, 1'b0, 34};
        vt[6] = '{1'b0, 32'd55,         32'd0,          32'hFFFF_FFFF, 32'h0000_0037, 1'b1, 1};
        vt[7] = '{1'b1, 32'd55,         32'd0,          32'hFFFF_FFFF, 32'h0000_0037, 1'b1, 1};
        for (int i = 0; i < 8; i++) begin
            run_op(vt[i].s, vt[i].a, vt[i].b, lat, bcnt, da, q, r, dz);
            total++;
            if (q !== vt[i].q || r !== vt[i].r || dz !== vt[i].dz) begin
                bad++;
                $display("FAIL directed[%0d] result: q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                         i, q, r, dz, vt[i].q, vt[i].r, vt[i].dz);
            end
            total++;
            if (lat !== vt[i].lat || bcnt !== vt[i].lat || da !== 1'b0) begin
                bad++;
                $display("FAIL directed[%0d] timing: lat=%0d busy=%0d done_next=%b, want lat=%0d busy=%0d done_next=0",
                         i, lat, bcnt, da, vt[i].lat, vt[i].lat);
            end
        end
    endtask

    task automatic test_dz_clear();
        int lat, bcnt;
        logic da, dz;
        logic [31:0] q, r;
        run_op(1'b0, 32'd55, 32'd0, lat, bcnt, da, q, r, dz);
        @(negedge clock);
        start = 1'b1; signed_op = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(posedge clock); #1;
        start = 1'b0;
        total++;
        if (div_by_zero !== 1'b0 || quotient !== 32'hFFFF_FFFF || remainder !== 32'd55 || busy !== 1'b1) begin
            bad++;
            $display("FAIL dz_clear accept: dz=%b q=%h r=%h busy=%b, want dz=0 q=ffffffff r=00000037 busy=1",
                     div_by_zero, quotient, remainder, busy);
        end
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        total++;
        if (lat !== 34 || quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
            bad++;
            $display("FAIL dz_clear result: lat=%0d q=%h r=%h dz=%b, want lat=34 q=0000000e r=00000002 dz=0",
                     lat, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_random();
        int lat, bcnt;
        logic da, dz, s, edz;
        logic [31:0] a, b, q, r, eq, er;
        for (int i = 0; i < 40; i++) begin
            s = $urandom_range(0, 1);
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom_range(0, 20);
                1:       b = -($urandom_range(1, 20));
                2:       b = {16'd0, 16'($urandom)};
                default: b = $urandom;
            endcase
            if (i % 7 == 3) a = 32'h8000_0000;
            model(s, a, b, eq, er, edz);
            run_op(s, a, b, lat, bcnt, da, q, r, dz);
            total++;
            if (q !== eq || r !== er || dz !== edz || lat !== (edz ? 1 : 34) || da !== 1'b0) begin
                bad++;
                $display("FAIL random[%0d] s=%b %h/%h: q=%h r=%h dz=%b lat=%0d, want q=%h r=%h dz=%b lat=%0d",
                         i, s, a, b, q, r, dz, lat, eq, er, edz, edz ? 1 : 34);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int lat;
        @(negedge clock);
        start = 1'b1; signed_op = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clock);
            start = (lat == 5);
            if (lat == 5) begin
                dividend = 32'd9; divisor = 32'd3;
            end
            @(posedge clock); #1;
            start = 1'b0;
            lat++;
        end
        total++;
        if (lat !== 34 || quotient !== 32'd14 || remainder !== 32'd2) begin
            bad++;
            $display("FAIL ignore_busy: lat=%0d q=%h r=%h, want lat=34 q=0000000e r=00000002",
                     lat, quotient, remainder);
        end
        @(posedge clock); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL ignore_busy idle: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_clear_mid();
        int lat, bcnt;
        logic da, dz;
        logic [31:0] q, r;
        @(negedge clock);
        start = 1'b1; signed_op = 1'b0; dividend = 32'd1000; divisor = 32'd9;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #2;
        clear = 1'b0;
        #1;
        total++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 67'd0) begin
            bad++;
            $display("FAIL clear_mid: busy=%b done=%b dz=%b q=%h r=%h, want all zero",
                     busy, done, div_by_zero, quotient, remainder);
        end
        @(negedge clock);
        clear = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL clear_mid idle: busy=%b done=%b, want 0 0", busy, done);
        end
        run_op(1'b0, 32'd9, 32'd3, lat, bcnt, da, q, r, dz);
        total++;
        if (q !== 32'd3 || r !== 32'd0 || dz !== 1'b0 || lat !== 34) begin
            bad++;
            $display("FAIL clear_mid after: q=%h r=%h dz=%b lat=%0d, want q=00000003 r=00000000 dz=0 lat=34",
                     q, r, dz, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_dz_clear();
        test_random();
        test_ignore_busy();
        test_clear_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_div32_seq
`default_nettype wire
